uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 10 +
 rtl/uart_rr_pick.sv | 16 +
 rtl/uart_tx_arbiter.sv | 88 ++++++++
 tb/tb_uart_tx_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared FSM encoding, byte width and defaults for the UART Tx arbiter
package uart_arb_pkg;
  localparam int BYTE_W = 8;
  localparam int STALL_LIMIT_DEF = 255;
  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT_DONE} state_t;
  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    oh2idx = '0;
    for (int i = 0; i < 8; i++) if (oh[i]) oh2idx = 3'(i);
  endfunction
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin pick, searching from last_owner+1 with wrap
// Ports: req (requests), last_owner (index of previous owner), pick (one-hot winner or zero)
module uart_rr_pick import uart_arb_pkg::*; #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_owner,
  output logic [NUM_REQ-1:0]         pick
);
  always_comb begin
    pick = '0;
    for (int k = 1; k <= NUM_REQ; k++)
      for (int i = 0; i < NUM_REQ; i++)
        if (pick == '0 && req[i] && i == (int'(last_owner) + k) % NUM_REQ) pick[i] = 1'b1;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: frame-locked round-robin arbiter feeding bytes to a single UART Tx
// Ports: clk/reset (sync, active high); req_valid/req_data/req_last/req_ready per requester;
//        tx_data/tx_start/EnTx/Done to the UART Tx; grant (one-hot owner), busy, frame_abort.
// Option: define UART_ARB_STALL_TIMEOUT_EN to abort a frame whose owner stalls STALL_LIMIT LOAD cycles.
module uart_tx_arbiter import uart_arb_pkg::*; #(
  parameter int NUM_REQ     = 2,
  parameter int STALL_LIMIT = STALL_LIMIT_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      tx_start,
  output logic                      EnTx,
  input  logic                      Done,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      frame_abort
);
  localparam int IW = $clog2(NUM_REQ);
  state_t state, state_nx;
  logic [NUM_REQ-1:0] pick;
  logic [IW-1:0] last_owner, owner_idx;
  logic [BYTE_W-1:0] sel_data;
  logic last_q, accept, stall_hit;
  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (.req(req_valid), .last_owner(last_owner), .pick(pick));
  assign accept = state == LOAD && |(req_valid & grant);
  assign owner_idx = IW'(oh2idx(8'(grant)));
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) if (grant[i]) sel_data = req_data[i*BYTE_W +: BYTE_W];
  end
`ifdef UART_ARB_STALL_TIMEOUT_EN
  localparam int CW = $clog2(STALL_LIMIT + 1);
  logic [CW-1:0] stall_cnt;
  // the hit fires on the STALL_LIMIT-th stalled LOAD cycle; abort pulses as the FSM lands in IDLE
  assign stall_hit = state == LOAD && !accept && stall_cnt == CW'(STALL_LIMIT - 1);
  always_ff @(posedge clk)
    if (reset) begin
      stall_cnt <= '0;
      frame_abort <= 1'b0;
    end else begin
      stall_cnt <= (state != LOAD || accept || stall_hit) ? '0 : stall_cnt + 1'b1;
      frame_abort <= stall_hit;
    end
`else
  assign stall_hit = 1'b0;
  assign frame_abort = 1'b0;
`endif
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = |req_valid ? LOAD : IDLE;
      LOAD:      state_nx = accept ? START : stall_hit ? IDLE : LOAD;
      START:     state_nx = WAIT_DONE;
      WAIT_DONE: state_nx = !Done ? WAIT_DONE : last_q ? IDLE : LOAD;
      default:   state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      grant <= '0;
      tx_data <= '0;
      last_q <= 1'b0;
      last_owner <= IW'(NUM_REQ - 1);
    end else begin
      if (state == IDLE) grant <= pick;
      if (accept) begin
        tx_data <= sel_data;
        last_q <= |(req_last & grant);
      end
      if ((state == WAIT_DONE && Done && last_q) || stall_hit) begin
        grant <= '0;
        last_owner <= owner_idx;
      end
    end
  always_comb begin
    req_ready = state == LOAD ? grant : '0;
    tx_start = state == START;
    EnTx = state == START || state == WAIT_DONE;
    busy = state != IDLE;
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized scoreboard bench for uart_tx_arbiter against a frame-level round-robin model
module tb_uart_tx_arbiter;
  localparam int NR = 2;
  localparam int SL = 4;
  localparam int MAXB = 64;
  logic clk = 1'b0;
  logic reset;
  logic [NR-1:0] req_valid, req_last, req_ready, grant;
  logic [8*NR-1:0] req_data;
  logic [7:0] tx_data;
  logic tx_start, EnTx, Done, busy, frame_abort;
  always #5 clk = ~clk;
  uart_tx_arbiter #(.NUM_REQ(NR), .STALL_LIMIT(SL)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start), .EnTx(EnTx), .Done(Done),
    .grant(grant), .busy(busy), .frame_abort(frame_abort)
  );
  typedef struct {logic [7:0] d; int owner;} exp_t;
  exp_t exp_q[$];
  int tests = 0, fails = 0;
  logic [7:0] bdat[NR][MAXB];
  logic blast[NR][MAXB];
  int bcnt[NR], bptr[NR], gap[NR];
  logic hold[NR], hold_arm[NR];
  int model_lo = NR - 1;
  int abort_cnt = 0, stall_seen = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask
  task automatic clear_src();
    for (int i = 0; i < NR; i++) begin
      bcnt[i] = 0; bptr[i] = 0; gap[i] = 0; hold[i] = 1'b0; hold_arm[i] = 1'b0;
    end
  endtask
  // frame-level model: whole frames are granted in round-robin order among requesters with frames left
  task automatic load_frames(input int maxf, input int maxlen);
    int nfr[NR], fidx[NR], pos[NR], total, c;
    int flen[NR][16];
    clear_src();
    total = 0;
    for (int i = 0; i < NR; i++) begin
      nfr[i] = $urandom_range(1, maxf); fidx[i] = 0; pos[i] = 0; total += nfr[i];
      for (int f = 0; f < nfr[i]; f++) begin
        flen[i][f] = $urandom_range(1, maxlen);
        for (int b = 0; b < flen[i][f]; b++) begin
          bdat[i][bcnt[i]] = 8'($urandom);
          blast[i][bcnt[i]] = b == flen[i][f] - 1;
          bcnt[i]++;
        end
      end
    end
    for (int n = 0; n < total; n++) begin
      c = -1;
      for (int k = 1; k <= NR; k++)
        if (c < 0 && fidx[(model_lo + k) % NR] < nfr[(model_lo + k) % NR]) c = (model_lo + k) % NR;
      for (int b = 0; b < flen[c][fidx[c]]; b++) begin
        exp_q.push_back('{bdat[c][pos[c]], c});
        pos[c]++;
      end
      fidx[c]++;
      model_lo = c;
    end
  endtask
  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 3000) begin
      fails++;
      $display("FAIL %s_drain: %0d bytes still expected after %0d cycles", name, exp_q.size(), n);
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_ready"}, 32'(req_ready), 0);
    chk({tag, "_start"}, 32'(tx_start), 0);
    chk({tag, "_entx"}, 32'(EnTx), 0);
    chk({tag, "_data"}, 32'(tx_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_abort"}, 32'(frame_abort), 0);
  endtask
  initial begin
    logic [NR-1:0] acc;
    req_valid = '0; req_data = '0; req_last = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) begin
          bptr[i]++;
          gap[i] = (bptr[i] < bcnt[i] && !blast[i][bptr[i] - 1]) ? $urandom_range(0, 2) : 0;
          if (hold_arm[i]) begin hold[i] = 1'b1; hold_arm[i] = 1'b0; end
        end else if (gap[i] > 0) gap[i]--;
        req_valid[i] = bptr[i] < bcnt[i] && gap[i] == 0 && !hold[i];
        req_data[8*i +: 8] = bptr[i] < bcnt[i] ? bdat[i][bptr[i]] : 8'($urandom);
        req_last[i] = blast[i][bptr[i]];
      end
    end
  end
  initial begin
    Done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      Done = 1'b0;
      if (tx_start) begin
        repeat ($urandom_range(1, 6)) begin @(posedge clk); #1; end
        Done = 1'b1;
      end else if (!EnTx && $urandom_range(0, 7) == 0) Done = 1'b1;
    end
  end
  initial begin
    exp_t e;
    logic [7:0] last_tx = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (tx_start) begin
          last_tx = tx_data;
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_start: got byte %0h expected no transmission", tx_data);
          end else begin
            e = exp_q.pop_front();
            chk("tx_data", 32'(tx_data), 32'(e.d));
            chk("grant_at_start", 32'(grant), 1 << e.owner);
          end
        end else if (EnTx) chk("tx_data_held", 32'(tx_data), 32'(last_tx));
        chk("ready_rule", 32'(req_ready), 32'((busy && !EnTx) ? grant : '0));
        chk("grant_onehot", 32'($onehot0(grant)), 1);
        if ((req_valid & req_ready) != '0) stall_seen = 0;
        else if (req_ready != '0) stall_seen++;
        if (frame_abort) begin
          abort_cnt++;
          chk("stall_cycles_at_abort", 32'(stall_seen), SL);
          chk("grant_after_abort", 32'(grant), 0);
        end
      end
    end
  end
  initial begin
    int n;
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < MAXB; j++) begin bdat[i][j] = '0; blast[i][j] = 1'b0; end
    clear_src();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    reset = 1'b0;
    @(negedge clk);
    load_frames(3, 4);
    @(negedge clk);
    chk("lat_c0_grant", 32'(grant), 0);
    chk("lat_c0_valid", 32'(req_valid), 32'({NR{1'b1}}));
    @(negedge clk);
    chk("lat_c1_grant", 32'(grant), 1);
    chk("lat_c1_ready", 32'(req_ready), 1);
    @(negedge clk);
    chk("lat_c2_start", 32'(tx_start), 1);
    wait_drain("first");
    for (int r = 0; r < 6; r++) begin
      load_frames(4, 4);
      wait_drain("random");
    end
    load_frames(4, 1);
    wait_drain("contention");
    load_frames(3, 4);
    n = 0;
    while (!(EnTx && !tx_start) && n < 500) begin @(negedge clk); n++; end
    chk("reach_wait_done", 32'(n < 500), 1);
    reset = 1'b1;
    clear_src();
    exp_q.delete();
    model_lo = NR - 1;
    @(negedge clk);
    chk_reset("midrst");
    reset = 1'b0;
    repeat (10) @(negedge clk);
    abort_cnt = 0;
    bdat[0][0] = 8'h41; blast[0][0] = 1'b0;
    bdat[0][1] = 8'h42; blast[0][1] = 1'b0;
    bdat[0][2] = 8'h43; blast[0][2] = 1'b1;
    bdat[1][0] = 8'h44; blast[1][0] = 1'b1;
    bcnt[0] = 3; bcnt[1] = 1;
    hold_arm[0] = 1'b1;
    exp_q.push_back('{8'h41, 0});
`ifdef UART_ARB_STALL_TIMEOUT_EN
    exp_q.push_back('{8'h44, 1});
    wait_drain("abort");
    chk("abort_count", 32'(abort_cnt), 1);
    chk("owner_bytes_taken", 32'(bptr[0]), 1);
    bcnt[0] = bptr[0];
    hold[0] = 1'b0;
`else
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    repeat (30) @(negedge clk);
    chk("stuck_busy", 32'(busy), 1);
    chk("stuck_grant", 32'(grant), 1);
    chk("stuck_ready", 32'(req_ready), 1);
    exp_q.push_back('{8'h42, 0});
    exp_q.push_back('{8'h43, 0});
    exp_q.push_back('{8'h44, 1});
    hold[0] = 1'b0;
    wait_drain("resume");
    chk("abort_count", 32'(abort_cnt), 0);
`endif
    model_lo = 1;
    for (int r = 0; r < 3; r++) begin
      load_frames(4, 3);
      wait_drain("final");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
